// File: rtl/uart_tx_peripheral_if.sv
// Address/control side of the shared processor bus as seen by the UART transmitter.
// The tri-state data bus stays a plain inout port on the peripheral itself.
interface uart_tx_peripheral_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with a small write FIFO, a status/control
// register pair, registered tri-state read-back and a "FIFO drained" interrupt.
module uart_tx_peripheral #(
    parameter logic [7:0]  BASE_ADDR  = 8'hB0,
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    uart_tx_peripheral_if.slave  bus,
    inout  wire  [7:0]           BUS_DATA,
    output logic                 UART_TX
);

    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  DEPTH_FULL  = 4'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic ptr_t ptr_inc(input ptr_t ptr);
        ptr_t nxt;
        if (ptr == PTR_LAST) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Bus decode
    logic [7:0] offset_s;
    logic       sel_s;
    logic       wr_fifo_s;
    logic       wr_status_s;
    logic       wr_ctrl_s;

    assign offset_s    = bus.BUS_ADDR - BASE_ADDR;
    assign sel_s       = (offset_s < 8'd3);
    assign wr_fifo_s   = sel_s & bus.BUS_WE & (offset_s == 8'd0);
    assign wr_status_s = sel_s & bus.BUS_WE & (offset_s == 8'd1);
    assign wr_ctrl_s   = sel_s & bus.BUS_WE & (offset_s == 8'd2);

    // FIFO and register state
    logic [7:0] mem_q [FIFO_DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic [3:0] count_q, count_d;
    logic       overrun_q, overrun_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;
    logic       rd_en_q, rd_en_d;
    logic [7:0] rd_data_q, rd_data_d;

    // Transmit engine state
    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic       tx_q, tx_d;

    logic       full_s;
    logic       empty_s;
    logic       push_s;
    logic       pop_s;
    logic       irq_event_s;
    logic       can_start_s;
    logic       baud_done_s;
    logic       busy_s;
    logic [7:0] head_s;
    logic [7:0] status_s;

    assign full_s      = (count_q == DEPTH_FULL);
    assign empty_s     = (count_q == 4'd0);
    assign push_s      = wr_fifo_s & ~full_s;
    assign can_start_s = ctrl_q[0] & ~empty_s;
    assign baud_done_s = (baud_cnt_q == 16'd0);
    assign busy_s      = (state_q != ST_IDLE);
    assign head_s      = mem_q[rd_ptr_q];
    assign status_s    = {count_q, overrun_q, busy_s, empty_s, full_s};

    // Transmit FSM: next state, shift/counter updates and the registered line level
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_cnt_d  = baud_cnt_q;
        tx_d        = tx_q;
        pop_s       = 1'b0;
        irq_event_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_start_s) begin
                    pop_s      = 1'b1;
                    shift_d    = head_s;
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = BAUD_RELOAD;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end else begin
                    tx_d       = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_cnt_d = BAUD_RELOAD;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // The line takes the next bit on the same edge the shifter advances
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    irq_event_s = empty_s;
                    if (can_start_s) begin
                        pop_s      = 1'b1;
                        shift_d    = head_s;
                        bit_cnt_d  = 3'd0;
                        baud_cnt_d = BAUD_RELOAD;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        tx_d       = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers, fill level, sticky overrun, control, interrupt and read-back
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        ctrl_d    = ctrl_q;
        irq_d     = irq_q;
        rd_en_d   = sel_s & ~bus.BUS_WE;
        rd_data_d = 8'h00;

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        if (wr_fifo_s & full_s) begin
            overrun_d = 1'b1;
        end else if (wr_status_s & BUS_DATA[3]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (wr_ctrl_s) begin
            ctrl_d = BUS_DATA[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        // A new drain event outranks an acknowledge landing on the same edge
        if (irq_event_s & ctrl_q[1]) begin
            irq_d = 1'b1;
        end else if (bus.BUS_INTERRUPT_ACK) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        case (offset_s)
            8'd1:    rd_data_d = status_s;
            8'd2:    rd_data_d = {6'b000000, ctrl_q};
            default: rd_data_d = 8'h00;
        endcase
    end

    // FIFO storage
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= BUS_DATA;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            overrun_q  <= 1'b0;
            ctrl_q     <= 2'b01;
            irq_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_data_q  <= 8'h00;
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            rd_en_q    <= rd_en_d;
            rd_data_q  <= rd_data_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign BUS_DATA                = rd_en_q ? rd_data_q : 8'hzz;
    assign bus.BUS_INTERRUPT_RAISE = irq_q;
    assign UART_TX                 = tx_q;

endmodule
